bits_to_bytes_packer: RTL and testbench

Streaming packer implementing Kyber BitsToBytes: accepts a serial bit stream LSB-first and emits packed bytes, B[i/8] += b[i]·2^(i mod 8). Sits directly downstream of the bytes-to-bits converter, or any bit-serial producer, and feeds byte-wide consumers (hash/encode stages). Frames are BYTE_COUNT bytes long; a small output FIFO absorbs consumer backpressure and misaligned frame ends are flagged.

---
 rtl/bits_to_bytes_packer_if.sv | 22 ++
 rtl/bits_to_bytes_packer.sv | 177 +++++++++++++++++
 tb/tb_bits_to_bytes_packer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bits_to_bytes_packer_if.sv
// Bit-stream input and byte-stream output handshakes of the bits-to-bytes packer.
// master = bit producer / byte consumer side, slave = packer.
interface bits_to_bytes_packer_if;
   logic       bit_valid;
   logic       bit_in;
   logic       bit_last;
   logic       bit_ready;
   logic       byte_valid;
   logic [7:0] byte_out;
   logic       byte_last;
   logic       byte_ready;

   modport master (
      output bit_valid, bit_in, bit_last, byte_ready,
      input  bit_ready, byte_valid, byte_out, byte_last
   );

   modport slave (
      input  bit_valid, bit_in, bit_last, byte_ready,
      output bit_ready, byte_valid, byte_out, byte_last
   );
endinterface

// File: rtl/bits_to_bytes_packer.sv
// Kyber BitsToBytes streaming packer: LSB-first serial bits in, framed bytes out
// through a small FIFO, with misaligned frame ends flagged on err_align.
module bits_to_bytes_packer #(
   parameter int BYTE_COUNT = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   bits_to_bytes_packer_if.slave  bus,
   output logic                   busy,
   output logic                   done,
   output logic                   err_align
);

   localparam int BCW = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [BCW-1:0] BCNT_LAST = BCW'(BYTE_COUNT - 1);
   localparam logic [PW:0]    CNT_FULL  = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_r;
   logic [7:0]       sr_r;
   logic [2:0]       bidx_r;
   logic [BCW-1:0]   bcnt_r;
   logic [8:0]       mem_r [FIFO_DEPTH];
   logic [PW-1:0]    wptr_r;
   logic [PW-1:0]    rptr_r;
   logic [PW:0]      cnt_r;
   logic             done_r;
   logic             err_r;

   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             completing_s;
   logic             ready_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic             last_pos_s;
   logic             frame_end_s;
   logic             misalign_s;
   logic [7:0]       packed_s;
   logic [8:0]       head_s;

   assign fifo_full_s  = (cnt_r == CNT_FULL);
   assign fifo_empty_s = (cnt_r == (PW+1)'(0));
   assign completing_s = (bidx_r == 3'd7) | bus.bit_last;
   assign last_pos_s   = (bcnt_r == BCNT_LAST) & (bidx_r == 3'd7);

   // Bit acceptance; a full FIFO stalls only the byte-completing bit, and a same-cycle pop does not bypass
   always_comb begin
      ready_s = 1'b0;
      if (!rst) begin
         ready_s = 1'b0;
      end else begin
         case (state_r)
            IDLE:    ready_s = 1'b1;
            PACK:    ready_s = !(completing_s & fifo_full_s);
            DRAIN:   ready_s = 1'b0;
            default: ready_s = 1'b0;
         endcase
      end
   end

   assign accept_s    = bus.bit_valid & ready_s;
   assign push_s      = accept_s & completing_s;
   assign pop_s       = !fifo_empty_s & bus.byte_ready;
   assign frame_end_s = accept_s & (bus.bit_last | last_pos_s);
   assign misalign_s  = frame_end_s & !(bus.bit_last & last_pos_s);

   // Byte being completed: bits above bidx are still zero in sr, which gives the padding
   always_comb begin
      packed_s         = sr_r;
      packed_s[bidx_r] = bus.bit_in;
   end

   // FIFO head presentation, zeroed while empty
   always_comb begin
      head_s = 9'd0;
      if (fifo_empty_s) begin
         head_s = 9'd0;
      end else begin
         head_s = mem_r[rptr_r];
      end
   end

   assign bus.bit_ready  = ready_s;
   assign bus.byte_valid = !fifo_empty_s;
   assign bus.byte_out   = head_s[7:0];
   assign bus.byte_last  = head_s[8];
   assign busy           = (state_r != IDLE);
   assign done           = done_r;
   assign err_align      = err_r;

   // Shift register, bit index and byte counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_r   <= 8'd0;
         bidx_r <= 3'd0;
         bcnt_r <= '0;
      end else if (accept_s) begin
         if (completing_s) begin
            sr_r   <= 8'd0;
            bidx_r <= 3'd0;
            bcnt_r <= frame_end_s ? '0 : (bcnt_r + BCW'(1));
         end else begin
            sr_r   <= packed_s;
            bidx_r <= bidx_r + 3'd1;
         end
      end
   end

   // Output FIFO storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 9'd0;
         end
         wptr_r <= '0;
         rptr_r <= '0;
         cnt_r  <= '0;
      end else begin
         if (push_s) begin
            mem_r[wptr_r] <= {frame_end_s, packed_s};
            wptr_r        <= wptr_r + PW'(1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + PW'(1);
         end
         if (push_s && !pop_s) begin
            cnt_r <= cnt_r + (PW+1)'(1);
         end else if (pop_s && !push_s) begin
            cnt_r <= cnt_r - (PW+1)'(1);
         end
      end
   end

   // Frame control FSM with registered done pulse and sticky alignment flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  err_r   <= misalign_s;
                  state_r <= frame_end_s ? DRAIN : PACK;
               end
            end
            PACK: begin
               if (frame_end_s) begin
                  err_r   <= misalign_s;
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop_s && !push_s && (cnt_r == (PW+1)'(1))) begin
                  state_r <= IDLE;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bits_to_bytes_packer.sv
// Scoreboard bench for bits_to_bytes_packer: frames are modelled as bit lists,
// expected bytes are queued at issue and a monitor compares on each byte handshake.
module tb_bits_to_bytes_packer;
   localparam int BC = 6;
   localparam int FD = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;
   logic done;
   logic err_align;

   bits_to_bytes_packer_if bus ();

   bits_to_bytes_packer #(.BYTE_COUNT(BC), .FIFO_DEPTH(FD)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .busy      (busy),
      .done      (done),
      .err_align (err_align)
   );

   always #5 clk = ~clk;

   int         n_checks  = 0;
   int         n_fail    = 0;
   int         stall_cnt = 0;
   int         rdy_mode  = 0;
   logic [8:0] exp_q [$];
   logic       fb [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add_byte(input logic [7:0] v);
      for (int k = 0; k < 8; k++) fb.push_back(v[k]);
   endfunction

   // Consumer readiness: 0 always ready, 1 random, 2 stalled
   initial begin
      bus.byte_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.byte_ready = 1'b1;
            1:       bus.byte_ready = 1'($urandom_range(0, 1));
            default: bus.byte_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares every accepted byte against the scoreboard head
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got %02h, nothing expected at %0t", bus.byte_out, $time);
            end else begin
               e = exp_q.pop_front();
               chk("byte", {23'd0, bus.byte_last, bus.byte_out}, {23'd0, e});
            end
         end
      end
   end

   task automatic send_bit(input logic b, input logic l);
      int t;
      bus.bit_valid = 1'b1;
      bus.bit_in    = b;
      bus.bit_last  = l;
      t = 0;
      forever begin
         @(negedge clk);
         if (bus.bit_ready === 1'b1) break;
         stall_cnt++;
         t++;
         if (t > 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL bit_timeout: bit_ready stuck at %0b, expected 1", bus.bit_ready);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Sends frame fb; expected bytes come from B[i/8] += b[i]*2^(i mod 8)
   task automatic run_frame(input logic with_last, input logic hold_valid);
      int   nb;
      int   nbytes;
      int   val;
      int   t;
      logic exp_err;
      nb     = fb.size();
      nbytes = (nb + 7) / 8;
      for (int j = 0; j < nbytes; j++) begin
         val = 0;
         for (int k = 0; k < 8; k++) begin
            if (8 * j + k < nb) val += int'(fb[8 * j + k]) * (2 ** k);
         end
         exp_q.push_back({(j == nbytes - 1), 8'(val)});
      end
      exp_err = !(with_last && nb == 8 * BC);
      for (int i = 0; i < nb; i++) begin
         send_bit(fb[i], with_last && (i == nb - 1));
         if (i == 0 && nb > 1) chk("err_clear", {31'd0, err_align}, 32'd0);
      end
      chk("err_at_end", {31'd0, err_align}, {31'd0, exp_err});
      chk("busy_drain", {31'd0, busy}, 32'd1);
      if (!hold_valid) bus.bit_valid = 1'b0;
      t = 0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) break;
         if (hold_valid) chk("refused", {31'd0, bus.bit_ready}, 32'd0);
         t++;
         if (t > 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: done stayed %0b, expected 1", done);
            break;
         end
      end
      bus.bit_valid = 1'b0;
      chk("done_err", {31'd0, err_align}, {31'd0, exp_err});
      chk("drained", exp_q.size(), 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      bus.bit_last  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bit_ready", {31'd0, bus.bit_ready}, 32'd0);
      chk("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
      chk("rst_byte_out", {24'd0, bus.byte_out}, 32'd0);
      chk("rst_byte_last", {31'd0, bus.byte_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err_align}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rel_bit_ready", {31'd0, bus.bit_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Aligned frame starting with 0xA5, consumer always ready
      fb = {};
      add_byte(8'hA5);
      for (int j = 1; j < BC; j++) add_byte(8'(j * 37));
      rdy_mode  = 0;
      stall_cnt = 0;
      run_frame(1'b1, 1'b0);
      chk("no_stall", stall_cnt, 32'd0);

      // Consumer stalled 40 cycles mid-frame: FIFO fills and the completing bit waits
      fb = {};
      for (int j = 0; j < BC; j++) add_byte(8'(j * 11 + 3));
      stall_cnt = 0;
      fork
         run_frame(1'b1, 1'b0);
         begin
            repeat (3) @(posedge clk);
            rdy_mode = 2;
            repeat (40) @(posedge clk);
            rdy_mode = 0;
         end
      join
      chk("stall_seen", {31'd0, (stall_cnt > 0)}, 32'd1);

      // Random frames, full or short, with random backpressure
      for (int f = 0; f < 6; f++) begin
         int nb;
         rdy_mode = 1;
         nb = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 8 * BC) : 8 * BC;
         fb = {};
         for (int i = 0; i < nb; i++) fb.push_back(1'($urandom_range(0, 1)));
         run_frame(1'b1, 1'b0);
      end

      // Early bit_last on bit 19, all ones: FF FF 0F
      rdy_mode = 0;
      fb = {};
      for (int i = 0; i < 20; i++) fb.push_back(1'b1);
      run_frame(1'b1, 1'b0);

      // Full-length frame without bit_last, producer keeps offering bits
      rdy_mode = 1;
      fb = {};
      for (int i = 0; i < 8 * BC; i++) fb.push_back(1'($urandom_range(0, 1)));
      run_frame(1'b0, 1'b1);

      // Reset mid-frame with one byte queued
      rdy_mode = 2;
      @(posedge clk);
      #1;
      for (int i = 0; i < 13; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      bus.bit_valid = 1'b0;
      @(negedge clk);
      chk("queued_before_rst", {31'd0, bus.byte_valid}, 32'd1);
      rst = 1'b0;
      #1;
      chk("midrst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_bit_ready", {31'd0, bus.bit_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst      = 1'b1;
      rdy_mode = 0;
      @(posedge clk);
      #1;

      // Frame after reset must carry no residue
      rdy_mode = 1;
      fb = {};
      for (int j = 0; j < BC; j++) add_byte(8'($urandom_range(0, 255)));
      run_frame(1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
